// File: rtl/id_stage_fwd.sv
// Registered decode stage for RV I-ALU / LOAD / R-type instructions with operand forwarding,
// load-use hazard detection and a valid/ready output register.
module id_stage_fwd #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RDATA_WIDTH = 64,
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned NUM_FWD     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [ADDR_WIDTH-1:0]          inst_addr_i,
  input  logic [DATA_WIDTH-1:0]          inst_i,
  output logic [RADDR_WIDTH-1:0]         reg1_raddr_o,
  output logic [RADDR_WIDTH-1:0]         reg2_raddr_o,
  input  logic [RDATA_WIDTH-1:0]         reg1_rdata_i,
  input  logic [RDATA_WIDTH-1:0]         reg2_rdata_i,
  input  logic [NUM_FWD-1:0]             fwd_we_i,
  input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*RDATA_WIDTH-1:0] fwd_wdata_i,
  input  logic                           fwd_is_load_i,
  input  logic                           flush_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [ADDR_WIDTH-1:0]          inst_addr_o,
  output logic [DATA_WIDTH-1:0]          inst_o,
  output logic [RDATA_WIDTH-1:0]         op1_o,
  output logic [RDATA_WIDTH-1:0]         op2_o,
  output logic                           reg_we_o,
  output logic [RADDR_WIDTH-1:0]         reg_waddr_o,
  output logic                           is_load_o,
  output logic [31:0]                    stall_cnt_o
);

  localparam logic [6:0]            OpImm  = 7'b0010011;
  localparam logic [6:0]            OpLoad = 7'b0000011;
  localparam logic [6:0]            OpReg  = 7'b0110011;
  localparam logic [DATA_WIDTH-1:0] Nop    = DATA_WIDTH'(32'h0000_0013);

  // Lowest-numbered (youngest) matching source wins; x0 always reads as zero.
  function automatic logic [RDATA_WIDTH-1:0] select_operand(
    input logic [RADDR_WIDTH-1:0] idx,
    input logic [RDATA_WIDTH-1:0] rf_data,
    input logic [NUM_FWD-1:0]     we,
    input logic [NUM_FWD*RADDR_WIDTH-1:0] waddr,
    input logic [NUM_FWD*RDATA_WIDTH-1:0] wdata
  );
    logic [RDATA_WIDTH-1:0] val;
    val = rf_data;
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (we[k] && (waddr[k*RADDR_WIDTH +: RADDR_WIDTH] == idx)) begin
        val = wdata[k*RDATA_WIDTH +: RDATA_WIDTH];
      end
    end
    if (idx == '0) begin
      val = '0;
    end
    return val;
  endfunction

  logic [6:0]             opcode;
  logic [RADDR_WIDTH-1:0] rs1_idx;
  logic [RADDR_WIDTH-1:0] rs2_idx;
  logic [RADDR_WIDTH-1:0] rd_idx;
  logic [RDATA_WIDTH-1:0] imm_sext;

  logic                   dec_re1;
  logic                   dec_re2;
  logic                   dec_we;
  logic                   dec_load;
  logic [DATA_WIDTH-1:0]  dec_inst;
  logic [RDATA_WIDTH-1:0] dec_op1;
  logic [RDATA_WIDTH-1:0] dec_op2;
  logic [RADDR_WIDTH-1:0] dec_waddr;

  logic [RADDR_WIDTH-1:0] load_dst;
  logic                   hazard;
  logic                   in_ready;
  logic                   fire;

  logic                   out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]  inst_addr_q, inst_addr_d;
  logic [DATA_WIDTH-1:0]  inst_q, inst_d;
  logic [RDATA_WIDTH-1:0] op1_q, op1_d;
  logic [RDATA_WIDTH-1:0] op2_q, op2_d;
  logic                   reg_we_q, reg_we_d;
  logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic                   is_load_q, is_load_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  always_comb begin
    opcode   = inst_i[6:0];
    rs1_idx  = RADDR_WIDTH'(inst_i[19:15]);
    rs2_idx  = RADDR_WIDTH'(inst_i[24:20]);
    rd_idx   = RADDR_WIDTH'(inst_i[11:7]);
    imm_sext = {{(RDATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
  end

  assign reg1_raddr_o = rs1_idx;
  assign reg2_raddr_o = rs2_idx;

  always_comb begin
    dec_re1   = 1'b0;
    dec_re2   = 1'b0;
    dec_we    = 1'b0;
    dec_load  = 1'b0;
    dec_inst  = Nop;
    dec_op1   = '0;
    dec_op2   = '0;
    dec_waddr = '0;
    unique case (opcode)
      OpImm, OpLoad: begin
        dec_re1   = 1'b1;
        dec_we    = 1'b1;
        dec_load  = (opcode == OpLoad);
        dec_inst  = inst_i;
        dec_waddr = rd_idx;
        dec_op1   = select_operand(rs1_idx, reg1_rdata_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
        dec_op2   = imm_sext;
      end
      OpReg: begin
        dec_re1   = 1'b1;
        dec_re2   = 1'b1;
        dec_we    = 1'b1;
        dec_inst  = inst_i;
        dec_waddr = rd_idx;
        dec_op1   = select_operand(rs1_idx, reg1_rdata_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
        dec_op2   = select_operand(rs2_idx, reg2_rdata_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
      end
      default: ;
    endcase
  end

  // A load in source 0 has no data yet, so a consumer of its destination must wait.
  always_comb begin
    load_dst = fwd_waddr_i[0 +: RADDR_WIDTH];
    hazard   = in_valid_i && fwd_is_load_i && fwd_we_i[0] && (load_dst != '0) &&
               ((dec_re1 && (rs1_idx == load_dst)) || (dec_re2 && (rs2_idx == load_dst)));
    in_ready = !rst_i && !flush_i && !hazard && (!out_valid_q || out_ready_i);
    fire     = in_valid_i && in_ready;
  end

  assign in_ready_o = in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    inst_addr_d = inst_addr_q;
    inst_d      = inst_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    reg_we_d    = reg_we_q;
    reg_waddr_d = reg_waddr_q;
    is_load_d   = is_load_q;
    stall_cnt_d = stall_cnt_q;

    if (hazard && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      inst_addr_d = inst_addr_i;
      inst_d      = dec_inst;
      op1_d       = dec_op1;
      op2_d       = dec_op2;
      reg_we_d    = dec_we;
      reg_waddr_d = dec_waddr;
      is_load_d   = dec_load;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      inst_addr_q <= '0;
      inst_q      <= Nop;
      op1_q       <= '0;
      op2_q       <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      is_load_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      inst_addr_q <= inst_addr_d;
      inst_q      <= inst_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      is_load_q   <= is_load_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign inst_addr_o = inst_addr_q;
  assign inst_o      = inst_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign is_load_o   = is_load_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: directed scenarios plus random traffic against a behavioural model
// of the decode/forward/hazard/handshake rules.
module tb_id_stage_fwd;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, fld, out_ready, out_valid;
  logic [31:0] addr, inst, addr_o, inst_o, stall_cnt;
  logic [4:0]  raddr1, raddr2, waddr_o;
  logic [63:0] rd1, rd2, op1, op2;
  logic [1:0]  fwe;
  logic [4:0]  fwa [2];
  logic [63:0] fwdat [2];
  logic        we_o, ld_o;

  logic [63:0] rf [32];

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the output register.
  logic        m_valid, m_we, m_ld;
  logic [31:0] m_addr, m_inst;
  logic [63:0] m_op1, m_op2;
  logic [4:0]  m_waddr;
  longint unsigned m_cnt;
  logic        obs_ready;

  always #5 clk = ~clk;

  id_stage_fwd dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .inst_addr_i   (addr),
    .inst_i        (inst),
    .reg1_raddr_o  (raddr1),
    .reg2_raddr_o  (raddr2),
    .reg1_rdata_i  (rd1),
    .reg2_rdata_i  (rd2),
    .fwd_we_i      (fwe),
    .fwd_waddr_i   ({fwa[1], fwa[0]}),
    .fwd_wdata_i   ({fwdat[1], fwdat[0]}),
    .fwd_is_load_i (fld),
    .flush_i       (flush),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .inst_addr_o   (addr_o),
    .inst_o        (inst_o),
    .op1_o         (op1),
    .op2_o         (op2),
    .reg_we_o      (we_o),
    .reg_waddr_o   (waddr_o),
    .is_load_o     (ld_o),
    .stall_cnt_o   (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value an instruction sees for register idx.
  function automatic logic [63:0] pick(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
    for (int k = 0; k < 2; k++) begin
      if (fwe[k] && fwa[k] == idx) return fwdat[k];
    end
    return rf[idx];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_we = 1'b0; m_ld = 1'b0; m_addr = '0; m_inst = 32'h13;
    m_op1 = '0; m_op2 = '0; m_waddr = '0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({pfx, ".stall"}, 64'(stall_cnt), m_cnt);
    if (m_valid) begin
      check({pfx, ".addr"}, 64'(addr_o), 64'(m_addr));
      check({pfx, ".inst"}, 64'(inst_o), 64'(m_inst));
      check({pfx, ".op1"}, op1, m_op1);
      check({pfx, ".op2"}, op2, m_op2);
      check({pfx, ".we"}, 64'(we_o), 64'(m_we));
      check({pfx, ".waddr"}, 64'(waddr_o), 64'(m_waddr));
      check({pfx, ".load"}, 64'(ld_o), 64'(m_ld));
    end
  endtask

  // Called just after a falling edge with inputs set; advances one clock.
  task automatic step(input string pfx);
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2;
    logic        legal, uses1, uses2, hz, rdy;
    logic [31:0] e_inst;
    logic [63:0] e_op1, e_op2;
    opc   = inst[6:0];
    rs1   = inst[19:15];
    rs2   = inst[24:20];
    rd1   = rf[rs1];
    rd2   = rf[rs2];
    #1;
    legal = (opc == 7'h13) || (opc == 7'h03) || (opc == 7'h33);
    uses1 = legal;
    uses2 = (opc == 7'h33);
    e_inst = legal ? inst : 32'h13;
    e_op1  = legal ? pick(rs1) : 64'd0;
    e_op2  = !legal ? 64'd0 : uses2 ? pick(rs2) : 64'(signed'(inst[31:20]));
    hz  = in_valid && fld && fwe[0] && fwa[0] != 0 &&
          ((uses1 && rs1 == fwa[0]) || (uses2 && rs2 == fwa[0]));
    rdy = !rst && !flush && !hz && (!m_valid || out_ready);
    obs_ready = in_ready;
    check({pfx, ".ready"}, 64'(in_ready), 64'(rdy));
    check({pfx, ".raddr1"}, 64'(raddr1), 64'(rs1));
    check({pfx, ".raddr2"}, 64'(raddr2), 64'(rs2));
    if (rst) begin
      model_reset();
    end else begin
      if (hz && !flush && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_valid = 1'b1; m_addr = addr; m_inst = e_inst; m_op1 = e_op1; m_op2 = e_op2;
        m_we = legal; m_waddr = legal ? inst[11:7] : 5'd0; m_ld = (opc == 7'h03);
      end else if (out_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(pfx);
  endtask

  task automatic idle_inputs();
    rst = 0; in_valid = 0; flush = 0; fld = 0; out_ready = 1; fwe = 0;
    fwa[0] = 0; fwa[1] = 0; fwdat[0] = 0; fwdat[1] = 0; addr = 0; inst = 32'h13;
  endtask

  logic [31:0] held_inst;
  logic [63:0] held_op1;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[1] = 64'd100;
    rf[2] = 64'd9;
    model_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    step("rst0");
    in_valid = 1;
    step("rst1");
    check("rst.ready_low", 64'(obs_ready), 64'd0);
    idle_inputs();
    check("rst.inst_nop", 64'(inst_o), 64'h13);
    check("rst.stall0", 64'(stall_cnt), 64'd0);
    step("idle");
    check("idle.ready_high", 64'(obs_ready), 64'd1);

    // addi x1,x0,-1
    in_valid = 1; addr = 32'h100; inst = 32'hfff00093;
    step("addi");
    check("addi.op2", op2, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi.waddr", 64'(waddr_o), 64'd1);
    check("addi.we", 64'(we_o), 64'd1);

    // or x3,x1,x2 with two sources writing x1
    addr = 32'h104; inst = 32'h0020E1B3;
    fwe = 2'b11; fwa[0] = 1; fwdat[0] = 5; fwa[1] = 1; fwdat[1] = 7;
    step("fwd");
    check("fwd.op1", op1, 64'd5);
    check("fwd.op2", op2, 64'd9);

    // Load-use on x1
    addr = 32'h108; fwe = 2'b01; fwa[0] = 1; fwdat[0] = 0; fld = 1;
    step("ldu");
    check("ldu.ready_low", 64'(obs_ready), 64'd0);
    check("ldu.bubble", 64'(out_valid), 64'd0);
    check("ldu.stall1", 64'(stall_cnt), 64'd1);
    fwe = 0; fld = 0;
    step("ldu_clr");
    check("ldu_clr.valid", 64'(out_valid), 64'd1);
    check("ldu_clr.op1", op1, 64'd100);

    // Backpressure with a new instruction waiting
    held_inst = inst_o; held_op1 = op1;
    out_ready = 0; addr = 32'h10c; inst = 32'h00500113;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check("hold.ready_low", 64'(obs_ready), 64'd0);
      check("hold.inst", 64'(inst_o), 64'(held_inst));
      check("hold.op1", op1, held_op1);
    end

    // Flush a held bundle, then forward into x0
    flush = 1;
    step("flush");
    check("flush.valid", 64'(out_valid), 64'd0);
    flush = 0; out_ready = 1; addr = 32'h110; inst = 32'h00006233;
    fwe = 2'b01; fwa[0] = 0; fwdat[0] = 64'd123;
    step("x0");
    check("x0.op1", op1, 64'd0);
    check("x0.op2", op2, 64'd0);

    // Random traffic over a small register window to provoke collisions
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      r         = $urandom;
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      fld       = $urandom_range(0, 1);
      fwe       = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        fwa[k]   = 5'($urandom_range(0, 3));
        fwdat[k] = {$urandom, $urandom};
      end
      addr = $urandom;
      case ($urandom_range(0, 3))
        0: r[6:0] = 7'h13;
        1: r[6:0] = 7'h03;
        2: r[6:0] = 7'h33;
        default: ;
      endcase
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      inst = r;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
